data_mem_initiator: RTL and testbench

Load/store sequencer that turns core-side memory requests into cycles on the data-memory bus. The bus consists of `data_addr`, `write_data`, `write_enable`, `output_enable` and a tri-stated `read_data` driven by the memory. The block sits between the execute stage and the data memory. It accepts one request at a time over a valid/ready handshake and splits 16-bit accesses into two little-endian byte cycles. It returns a response, including read data, over a second valid/ready handshake.

---
 rtl/data_mem_initiator_if.sv | 64 ++++++
 rtl/data_mem_initiator.sv | 134 +++++++++++++
 tb/tb_data_mem_initiator.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/data_mem_initiator_if.sv
// Bundle of the core-side request/response handshakes and the data-memory bus.
// master: the load/store sequencer; slave: core plus memory on the far side.
//   req_*          core request (valid/ready), write flag, size, address, data
//   rsp_*          response (valid/ready) with load data
//   data_addr      memory byte address
//   write_data     memory write byte
//   write_enable   memory write strobe
//   output_enable  memory read-drive enable
//   read_data      memory read byte, valid while output_enable = 1
interface data_mem_initiator_if #(
    parameter int D_ADDR_W = 12,
    parameter int DATA_W   = 8
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic                  req_half;
    logic [D_ADDR_W-1:0]   req_addr;
    logic [2*DATA_W-1:0]   req_wdata;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [2*DATA_W-1:0]   rsp_rdata;

    logic [D_ADDR_W-1:0]   data_addr;
    logic [DATA_W-1:0]     write_data;
    logic                  write_enable;
    logic                  output_enable;
    logic [DATA_W-1:0]     read_data;

    modport master (
        input  req_valid,
        input  req_write,
        input  req_half,
        input  req_addr,
        input  req_wdata,
        output req_ready,
        output rsp_valid,
        input  rsp_ready,
        output rsp_rdata,
        output data_addr,
        output write_data,
        output write_enable,
        output output_enable,
        input  read_data
    );

    modport slave (
        output req_valid,
        output req_write,
        output req_half,
        output req_addr,
        output req_wdata,
        input  req_ready,
        input  rsp_valid,
        output rsp_ready,
        input  rsp_rdata,
        input  data_addr,
        input  write_data,
        input  write_enable,
        input  output_enable,
        output read_data
    );
endinterface

// File: rtl/data_mem_initiator.sv
// Load/store sequencer: one core request at a time, split into byte cycles
// on the data-memory bus (little-endian for half-words), then a response.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    data_mem_initiator_if.master (request, response, memory bus)
module data_mem_initiator #(
    parameter int D_ADDR_W = 12,
    parameter int DATA_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    data_mem_initiator_if.master   bus
);

    typedef enum logic [1:0] {
        IDLE,
        ACC_LO,
        ACC_HI,
        RESP
    } state_t;

    localparam logic [D_ADDR_W-1:0] ADDR_ONE = D_ADDR_W'(1);

    state_t                state;
    state_t                state_nx;

    logic                  lat_write;
    logic                  lat_half;
    logic [D_ADDR_W-1:0]   lat_addr;
    logic [2*DATA_W-1:0]   lat_wdata;
    logic [2*DATA_W-1:0]   rdata_q;
    logic [D_ADDR_W-1:0]   addr_q;

    logic                  req_ready;
    logic                  rsp_valid;
    logic                  in_acc;
    logic [DATA_W-1:0]     write_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx   = state;
        req_ready  = 1'b0;
        rsp_valid  = 1'b0;
        in_acc     = 1'b0;
        write_data = '0;
        unique case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (bus.req_valid) begin
                    state_nx = ACC_LO;
                end
            end
            ACC_LO: begin
                in_acc     = 1'b1;
                write_data = lat_wdata[DATA_W-1:0];
                state_nx   = lat_half ? ACC_HI : RESP;
            end
            ACC_HI: begin
                in_acc     = 1'b1;
                write_data = lat_wdata[2*DATA_W-1:DATA_W];
                state_nx   = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_nx = IDLE;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // The address is a register so it holds its last value outside the
    // access states; it is loaded on accept and bumped for the high byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lat_write <= 1'b0;
            lat_half  <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            rdata_q   <= '0;
            addr_q    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        lat_write <= bus.req_write;
                        lat_half  <= bus.req_half;
                        lat_addr  <= bus.req_addr;
                        lat_wdata <= bus.req_wdata;
                        rdata_q   <= '0;
                        addr_q    <= bus.req_addr;
                    end
                end
                ACC_LO: begin
                    if (!lat_write) begin
                        rdata_q[DATA_W-1:0] <= bus.read_data;
                    end
                    if (lat_half) begin
                        addr_q <= lat_addr + ADDR_ONE;
                    end
                end
                ACC_HI: begin
                    if (!lat_write) begin
                        rdata_q[2*DATA_W-1:DATA_W] <= bus.read_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Strobes decode from state, so reset drops them without waiting
    // for a clock edge.
    assign bus.write_enable  = in_acc & lat_write;
    assign bus.output_enable = in_acc & ~lat_write;
    assign bus.write_data    = write_data;
    assign bus.data_addr     = addr_q;
    assign bus.req_ready     = req_ready;
    assign bus.rsp_valid     = rsp_valid;
    assign bus.rsp_rdata     = rdata_q;

endmodule

// File: tb/tb_data_mem_initiator.sv
// Directed bench for data_mem_initiator with a byte-wide memory model.
// Checks latency, bus cycles, back-pressure, reset abort and a random mix.
module tb_data_mem_initiator;

    localparam int AW = 12;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n;
    logic clr_mem;
    logic mon_on;

    int n_checks = 0;
    int n_errors = 0;

    logic [DW-1:0] mem     [0:(1<<AW)-1];
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];

    always #5 clk = ~clk;

    data_mem_initiator_if #(.D_ADDR_W(AW), .DATA_W(DW)) bus ();

    data_mem_initiator #(.D_ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < (1 << AW); i++) begin
                mem[i] <= '0;
            end
        end else if (bus.write_enable) begin
            mem[bus.data_addr] <= bus.write_data;
        end
    end

    assign bus.read_data = bus.output_enable ? mem[bus.data_addr] : '0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            check("excl", 32'(bus.write_enable & bus.output_enable), 32'd0);
        end
    end

    // Called at a negedge with the block idle; returns at a negedge in IDLE.
    task automatic run_op(input string tag, input logic w, input logic h,
                          input logic [AW-1:0] a, input logic [15:0] wd,
                          input logic [15:0] exp);
        int n;
        logic [AW-1:0] a1;
        a1 = a + 12'd1;
        n = 0;
        while (!bus.req_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".rdy"}, 32'(bus.req_ready), 32'd1);
        bus.req_write = w;
        bus.req_half  = h;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check({tag, ".lo_addr"}, 32'(bus.data_addr), 32'(a));
        check({tag, ".lo_we"}, 32'(bus.write_enable), 32'(w));
        check({tag, ".lo_oe"}, 32'(bus.output_enable), 32'(!w));
        check({tag, ".lo_wd"}, 32'(bus.write_data), 32'(wd[7:0]));
        check({tag, ".lo_rv"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, ".lo_rr"}, 32'(bus.req_ready), 32'd0);
        if (h) begin
            @(negedge clk);
            check({tag, ".hi_addr"}, 32'(bus.data_addr), 32'(a1));
            check({tag, ".hi_we"}, 32'(bus.write_enable), 32'(w));
            check({tag, ".hi_oe"}, 32'(bus.output_enable), 32'(!w));
            check({tag, ".hi_wd"}, 32'(bus.write_data), 32'(wd[15:8]));
            check({tag, ".hi_rv"}, 32'(bus.rsp_valid), 32'd0);
        end
        @(negedge clk);
        check({tag, ".rsp_v"}, 32'(bus.rsp_valid), 32'd1);
        check({tag, ".rsp_d"}, 32'(bus.rsp_rdata), 32'(exp));
        check({tag, ".rsp_we"}, 32'(bus.write_enable), 32'd0);
        check({tag, ".rsp_oe"}, 32'(bus.output_enable), 32'd0);
        check({tag, ".rsp_wd"}, 32'(bus.write_data), 32'd0);
        check({tag, ".rsp_addr"}, 32'(bus.data_addr), 32'(h ? a1 : a));
        check({tag, ".rsp_rr"}, 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        check({tag, ".idle_rr"}, 32'(bus.req_ready), 32'd1);
        check({tag, ".idle_rv"}, 32'(bus.rsp_valid), 32'd0);
        if (w) begin
            ref_mem[a] = wd[7:0];
            if (h) begin
                ref_mem[a1] = wd[15:8];
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ".rr"}, 32'(bus.req_ready), 32'd1);
        check({tag, ".rv"}, 32'(bus.rsp_valid), 32'd0);
        check({tag, ".rd"}, 32'(bus.rsp_rdata), 32'd0);
        check({tag, ".addr"}, 32'(bus.data_addr), 32'd0);
        check({tag, ".wd"}, 32'(bus.write_data), 32'd0);
        check({tag, ".we"}, 32'(bus.write_enable), 32'd0);
        check({tag, ".oe"}, 32'(bus.output_enable), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic          w;
        logic          h;
        logic [AW-1:0] a;
        logic [AW-1:0] a1;
        logic [15:0]   wd;
        logic [15:0]   exp;

        for (int i = 0; i < (1 << AW); i++) begin
            ref_mem[i] = '0;
        end
        mon_on        = 1'b0;
        clr_mem       = 1'b1;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_half  = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b0;
        #1;
        check_reset_vals("rst");
        @(negedge clk);
        @(negedge clk);
        clr_mem = 1'b0;
        rst_n   = 1'b1;
        mon_on  = 1'b1;
        @(negedge clk);

        run_op("st_b", 1'b1, 1'b0, 12'h010, 16'h00A5, 16'h0000);
        check("mem010", 32'(mem[12'h010]), 32'h0A5);
        run_op("ld_b", 1'b0, 1'b0, 12'h010, 16'h0000, 16'h00A5);
        run_op("st_h", 1'b1, 1'b1, 12'h020, 16'hBEEF, 16'h0000);
        check("mem020", 32'(mem[12'h020]), 32'h0EF);
        check("mem021", 32'(mem[12'h021]), 32'h0BE);
        run_op("ld_h", 1'b0, 1'b1, 12'h020, 16'h0000, 16'hBEEF);
        run_op("st_w", 1'b1, 1'b1, 12'hFFF, 16'h1234, 16'h0000);
        check("memfff", 32'(mem[12'hFFF]), 32'h034);
        check("mem000", 32'(mem[12'h000]), 32'h012);
        run_op("ld_w", 1'b0, 1'b0, 12'h000, 16'h0000, 16'h0012);

        // Back-pressure: half load held in RESP, second request waits.
        bus.req_write = 1'b0;
        bus.req_half  = 1'b1;
        bus.req_addr  = 12'h020;
        bus.req_wdata = 16'h0000;
        bus.req_valid = 1'b1;
        bus.rsp_ready = 1'b0;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        bus.req_half  = 1'b0;
        bus.req_addr  = 12'h010;
        bus.req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp.rv", 32'(bus.rsp_valid), 32'd1);
            check("bp.rd", 32'(bus.rsp_rdata), 32'hBEEF);
            check("bp.rr", 32'(bus.req_ready), 32'd0);
            check("bp.addr", 32'(bus.data_addr), 32'h021);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp.idle_rr", 32'(bus.req_ready), 32'd1);
        check("bp.idle_rv", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(negedge clk);
        check("bp2.lo_addr", 32'(bus.data_addr), 32'h010);
        check("bp2.lo_oe", 32'(bus.output_enable), 32'd1);
        @(negedge clk);
        check("bp2.rv", 32'(bus.rsp_valid), 32'd1);
        check("bp2.rd", 32'(bus.rsp_rdata), 32'h00A5);
        @(negedge clk);
        check("bp2.idle_rr", 32'(bus.req_ready), 32'd1);

        // Reset during the high byte of a half-word store.
        run_op("st_41", 1'b1, 1'b0, 12'h041, 16'h0077, 16'h0000);
        bus.req_write = 1'b1;
        bus.req_half  = 1'b1;
        bus.req_addr  = 12'h040;
        bus.req_wdata = 16'hCAFE;
        bus.req_valid = 1'b1;
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        @(posedge clk);
        #2;
        check("ab.hi_we", 32'(bus.write_enable), 32'd1);
        check("ab.hi_addr", 32'(bus.data_addr), 32'h041);
        mon_on = 1'b0;
        rst_n  = 1'b0;
        #1;
        check_reset_vals("ab");
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        mon_on = 1'b1;
        check("ab.mem040", 32'(mem[12'h040]), 32'h0FE);
        check("ab.mem041", 32'(mem[12'h041]), 32'h077);
        ref_mem[12'h040] = 8'hFE;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("ab.no_rsp", 32'(bus.rsp_valid), 32'd0);
            check("ab.rr", 32'(bus.req_ready), 32'd1);
        end

        // Random mix against the reference byte array.
        for (int i = 0; i < 200; i++) begin
            w  = 1'($urandom_range(0, 1));
            h  = 1'($urandom_range(0, 1));
            a  = AW'($urandom_range(0, (1 << AW) - 1));
            a1 = a + 12'd1;
            wd = 16'($urandom);
            if (w) begin
                exp = 16'h0000;
            end else if (h) begin
                exp = {ref_mem[a1], ref_mem[a]};
            end else begin
                exp = {8'h00, ref_mem[a]};
            end
            run_op("rnd", w, h, a, wd, exp);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
